// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter and clear sequencer for the scratch RAM
module ram_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data
);

    typedef enum logic [2:0] {IDLE, ACCESS, RDWAIT, DONE, CLEAR} state_t;

    state_t            state, state_next;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              grant_b;
    logic              last_grant_b;
    logic              clear_pend;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clear_go;
    logic              pick_b;
    logic              clr_last;

    assign clear_go = clear_req || clear_pend;
    // B wins only when A is idle or A was served last
    assign pick_b   = req_b && (!req_a || !last_grant_b);
    assign clr_last = (clr_cnt == {ADDR_W{1'b1}});

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_go)
                    state_next = CLEAR;
                else if (req_a || req_b)
                    state_next = ACCESS;
            end
            ACCESS:  state_next = cmd_we ? DONE : RDWAIT;
            RDWAIT:  state_next = DONE;
            DONE:    state_next = IDLE;
            CLEAR:   state_next = clr_last ? IDLE : CLEAR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd_we       <= 1'b0;
            cmd_addr     <= '0;
            cmd_wdata    <= '0;
            grant_b      <= 1'b0;
            last_grant_b <= 1'b1;
            clear_pend   <= 1'b0;
            clr_cnt      <= '0;
            clear_done   <= 1'b0;
            rdata_a      <= '0;
            rdata_b      <= '0;
        end else begin
            state      <= state_next;
            clear_done <= (state == CLEAR) && clr_last;
            if (state == IDLE) begin
                if (clear_go) begin
                    clr_cnt    <= '0;
                    clear_pend <= 1'b0;
                end else if (req_a || req_b) begin
                    grant_b      <= pick_b;
                    last_grant_b <= pick_b;
                    cmd_we       <= pick_b ? we_b    : we_a;
                    cmd_addr     <= pick_b ? addr_b  : addr_a;
                    cmd_wdata    <= pick_b ? wdata_b : wdata_a;
                end
            end else if (clear_req) begin
                clear_pend <= 1'b1;
            end
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (state == RDWAIT) begin
                if (grant_b)
                    rdata_b <= ram_read_data;
                else
                    rdata_a <= ram_read_data;
            end
        end
    end

    always_comb begin
        ram_write_en   = 1'b0;
        ram_addr       = '0;
        ram_write_data = '0;
        case (state)
            ACCESS: begin
                ram_write_en   = cmd_we;
                ram_addr       = cmd_addr;
                ram_write_data = cmd_wdata;
            end
            RDWAIT: ram_addr = cmd_addr;
            CLEAR: begin
                ram_write_en = 1'b1;
                ram_addr     = clr_cnt;
            end
            default: ;
        endcase
    end

    assign ack_a = (state == DONE) && !grant_b;
    assign ack_b = (state == DONE) && grant_b;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          ack_a, ack_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          clear_req, clear_done, busy;
    logic          ram_write_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_write_data, ram_read_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
        .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    // Single-port RAM with registered read, zeroed by the shared reset
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            ram_read_data <= '0;
        end else begin
            if (ram_write_en) mem[ram_addr] <= ram_write_data;
            ram_read_data <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request, hold until ack (bounded), drop req in the ack cycle, step into IDLE
    task automatic port_xfer(input bit sel_b, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
        if (sel_b) begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
        else       begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (sel_b ? ack_b : ack_a) begin
                lat = c;
                rd  = sel_b ? rdata_b : rdata_a;
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        clear_req = 0;
        tick(); tick();
        total++;
        if ({ack_a, ack_b, rdata_a, rdata_b, clear_done, busy, ram_write_en, ram_addr, ram_write_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ack_a=%b ack_b=%b rdata_a=%h rdata_b=%h clear_done=%b busy=%b we=%b addr=%h wd=%h, want all 0",
                     ack_a, ack_b, rdata_a, rdata_b, clear_done, busy, ram_write_en, ram_addr, ram_write_data);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (ram_write_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet cyc%0d: we=%b busy=%b, want 0 0", c, ram_write_en, busy);
            end
        end
    endtask

    task automatic test_single_port;
        logic [DW-1:0] rd;
        int lat;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 8'hA5;
        tick();
        total++;
        if ({busy, ram_write_en, ram_addr, ram_write_data} !== {1'b1, 1'b1, 3'd3, 8'hA5}) begin
            bad++;
            $display("FAIL write_access: busy=%b we=%b addr=%h wd=%h, want 1 1 3 a5", busy, ram_write_en, ram_addr, ram_write_data);
        end
        tick();
        total++;
        if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
            bad++;
            $display("FAIL write_ack_cycle2: ack_a=%b ack_b=%b, want 1 0", ack_a, ack_b);
        end
        req_a = 1'b0;
        tick();
        total++;
        if (ack_a !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL write_idle_cycle3: ack_a=%b busy=%b, want 0 0", ack_a, busy);
        end
        port_xfer(1'b0, 1'b0, 3'd3, 8'h00, rd, lat);
        total++;
        if (lat !== 3 || rd !== 8'hA5) begin
            bad++;
            $display("FAIL read_a: latency=%0d rdata=%h, want 3 a5", lat, rd);
        end
    endtask

    task automatic test_fairness;
        bit seq [4];
        int at  [4];
        int n = 0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd3;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd6;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            tick();
            if (ack_a && ack_b) begin
                total++; bad++;
                $display("FAIL fair_double_ack cyc%0d: both acks high", c);
            end
            if (ack_a || ack_b) begin
                seq[n] = ack_b;
                at[n]  = c;
                total++;
                if (ack_a ? (rdata_a !== 8'hA5) : (rdata_b !== 8'h00)) begin
                    bad++;
                    $display("FAIL fair_rdata grant%0d: rdata_a=%h rdata_b=%h, want a5 / 00", n, rdata_a, rdata_b);
                end
                n++;
                if (n == 4) begin req_a = 1'b0; req_b = 1'b0; end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL fair_count: grants=%0d, want 4", n);
        end else begin
            total++;
            if (seq[0] !== 1'b1 || at[0] != 3) begin
                bad++;
                $display("FAIL fair_first: port_b=%b cycle=%0d, want 1 3", seq[0], at[0]);
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (seq[i] === seq[i-1] || at[i] - at[i-1] != 4) begin
                    bad++;
                    $display("FAIL fair_alternate grant%0d: port_b=%b gap=%0d, want %b 4", i, seq[i], at[i] - at[i-1], !seq[i-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_clear_while_busy;
        logic [DW-1:0] rd;
        int lat;
        port_xfer(1'b1, 1'b1, 3'd6, 8'h5C, rd, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL cwb_write_b: latency=%0d, want 2", lat);
        end
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd6;
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        total++;
        if (ack_b !== 1'b1 || rdata_b !== 8'h5C) begin
            bad++;
            $display("FAIL cwb_read_b: ack_b=%b rdata_b=%h, want 1 5c", ack_b, rdata_b);
        end
        req_b = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL cwb_idle_gap: busy=%b, want 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({busy, ram_write_en, ram_addr, ram_write_data, clear_done} !== {1'b1, 1'b1, 3'(i), 8'h00, 1'b0}) begin
                bad++;
                $display("FAIL cwb_clear step%0d: busy=%b we=%b addr=%0d wd=%h done=%b, want 1 1 %0d 00 0",
                         i, busy, ram_write_en, ram_addr, ram_write_data, clear_done, i);
            end
        end
        tick();
        total++;
        if (clear_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cwb_done: clear_done=%b busy=%b, want 1 0", clear_done, busy);
        end
        tick();
        total++;
        if (clear_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cwb_single_clear: clear_done=%b busy=%b, want 0 0", clear_done, busy);
        end
        port_xfer(1'b0, 1'b0, 3'd6, 8'h00, rd, lat);
        total++;
        if (lat !== 3 || rd !== 8'h00) begin
            bad++;
            $display("FAIL cwb_readback: latency=%0d rdata=%h, want 3 00", lat, rd);
        end
    endtask

    task automatic test_clear_priority;
        logic [DW-1:0] rd;
        int lat;
        port_xfer(1'b0, 1'b1, 3'd3, 8'h3C, rd, lat);
        clear_req = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd3;
        tick();
        clear_req = 1'b0;
        total++;
        if ({busy, ram_write_en, ram_addr, ack_a} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL prio_clear_first: busy=%b we=%b addr=%0d ack_a=%b, want 1 1 0 0", busy, ram_write_en, ram_addr, ack_a);
        end
        for (int i = 1; i < 8; i++) tick();
        total++;
        if (ram_addr !== 3'd7 || ram_write_en !== 1'b1) begin
            bad++;
            $display("FAIL prio_clear_last: addr=%0d we=%b, want 7 1", ram_addr, ram_write_en);
        end
        tick();
        total++;
        if (clear_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL prio_done: clear_done=%b busy=%b, want 1 0", clear_done, busy);
        end
        tick();
        total++;
        if ({busy, ram_write_en, ram_addr} !== {1'b1, 1'b0, 3'd3}) begin
            bad++;
            $display("FAIL prio_a_access: busy=%b we=%b addr=%0d, want 1 0 3", busy, ram_write_en, ram_addr);
        end
        tick(); tick();
        total++;
        if (ack_a !== 1'b1 || rdata_a !== 8'h00) begin
            bad++;
            $display("FAIL prio_a_read: ack_a=%b rdata_a=%h, want 1 00", ack_a, rdata_a);
        end
        req_a = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort;
        logic [DW-1:0] rd;
        int lat;
        int acks = 0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd1; wdata_a = 8'hFF;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = 1'b0;
        total++;
        if ({busy, ack_a, ram_write_en} !== 3'b000) begin
            bad++;
            $display("FAIL abort_idle: busy=%b ack_a=%b we=%b, want 0 0 0", busy, ack_a, ram_write_en);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack_a || ack_b || clear_done) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL abort_no_ack: stray pulses=%0d, want 0", acks);
        end
        port_xfer(1'b0, 1'b0, 3'd1, 8'h00, rd, lat);
        total++;
        if (lat !== 3 || rd !== 8'h00) begin
            bad++;
            $display("FAIL abort_readback: latency=%0d rdata=%h, want 3 00", lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_fairness();
        test_clear_while_busy();
        test_clear_priority();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the 8×8 single-port scratch RAM. It shares the RAM between requester A and requester B through a req/ack handshake. It returns read data in a per-port register, and it can run a background clear sequence that zero-fills all eight locations. It sits directly in front of the RAM and owns the RAM's write_en, addr and write_data pins.

## Interface
- ADDR_W, 3: RAM address width; depth is 2**ADDR_W.
- DATA_W, 8: RAM data width.

- clk, in, 1: clock; all logic is rising-edge.
- reset, in, 1: synchronous, active-high reset.
- req_a / req_b, in, 1: access request; the requester holds it high until ack.
- we_a / we_b, in, 1: 1 = write, 0 = read; held stable while req is high.
- addr_a / addr_b, in, ADDR_W: target address; held stable while req is high.
- wdata_a / wdata_b, in, DATA_W: write data; held stable while req is high.
- ack_a / ack_b, out, 1: one-cycle completion pulse.
- rdata_a / rdata_b, out, DATA_W: read result; valid while ack is high for a read and held until that port's next read completes.
- clear_req, in, 1: one-cycle pulse that requests a zero-fill of the whole RAM.
- clear_done, out, 1: one-cycle pulse when the zero-fill completes.
- busy, out, 1: high whenever the FSM is not in IDLE.
- ram_write_en, out, 1: drives the RAM write_en.
- ram_addr, out, ADDR_W: drives the RAM addr.
- ram_write_data, out, DATA_W: drives the RAM write_data.
- ram_read_data, in, DATA_W: the RAM's registered read_data.

## Operation
- FSM states: IDLE, ACCESS, RDWAIT, DONE, CLEAR.
- IDLE:
  - If clear is pending (clear_req seen now or latched earlier), go to CLEAR. Clear has priority over port requests.
  - Otherwise, if any req is high, grant one port, latch its we/addr/wdata into command registers, and go to ACCESS.
  - If both ports request, grant the port that was not granted last.
  - The last_grant register resets to B, so A wins the first tie.
  - last_grant updates on every grant.
- ACCESS:
  - ram_addr and ram_write_data come from the command registers.
  - ram_write_en equals the latched we.
  - Next state is DONE for a write, RDWAIT for a read.
- RDWAIT:
  - ram_write_en is 0 and ram_addr is held.
  - ram_read_data is valid in this state; capture it into the granted port's rdata register at the end of the cycle.
  - Next state is DONE.
- DONE:
  - The granted port's ack is high for exactly this cycle.
  - No arbitration happens in DONE.
  - Next state is IDLE.
- CLEAR:
  - ram_write_en = 1 and ram_write_data = 0.
  - ram_addr counts 0 to 7, one location per cycle.
  - After address 7 is written, pulse clear_done for one cycle, coinciding with the return to IDLE.
- Outside ACCESS and CLEAR, ram_write_en is 0. Background RAM reads in those cycles are harmless and ignored.
- A clear_req pulse that arrives while busy is latched as pending and serviced at the next IDLE. Multiple pending pulses collapse into one clear.
- A clear_req that arrives during CLEAR is latched and causes a second full clear.
- If req is still high in the IDLE cycle after ack, it is treated as a new request (back-to-back access).
- The address counter wraps only in CLEAR and never indexes past 7.

## Timing
- Cycle n means the interval after rising edge n. A req first high in cycle 0 is sampled at edge 1.
- Write: ACCESS in cycle 1, RAM write at edge 2, ack in cycle 2, IDLE in cycle 3. Total of 3 cycles from req to a free arbiter.
- Read: ACCESS in cycle 1, RAM registers at edge 2, RDWAIT in cycle 2, rdata captured at edge 3, ack and rdata valid in cycle 3, IDLE in cycle 4.
- Clear: 8 write cycles plus a clear_done pulse in the cycle IDLE is re-entered.
- Reset values:
  - All outputs are 0: ack_a, ack_b, rdata_a, rdata_b, clear_done, busy, ram_write_en, ram_addr, ram_write_data.
  - State is IDLE, last_grant = B, clear pending = 0.
- Reset mid-operation: the transaction is aborted with no ack and no clear_done. A pending clear is dropped. The RAM itself is cleared by the shared reset.

## Test plan
- Reset check: after reset, all outputs are 0 and busy is 0. Hold req_a = 0 and verify ram_write_en never rises.
- Single port: A writes addr 3 ← 0xA5 and ack_a appears in cycle 2. A then reads addr 3, and ack_a with rdata_a = 0xA5 appears in cycle 3 after req.
- Fairness: A and B both hold read requests continuously. Grants alternate A, B, A, B; neither port is granted twice in a row.
- Clear while busy: pulse clear_req during B's ACCESS for a read of 0x5C at addr 6. B still gets ack_b with rdata_b = 0x5C. Then clear runs 8 cycles with addr 0..7, followed by clear_done. A subsequent read of addr 6 returns 0x00.
- Clear priority: clear_req and req_a arrive in the same IDLE cycle. CLEAR runs first, and A's access starts in the cycle after clear_done.
- Reset abort: assert reset during A's ACCESS write of 0xFF to addr 1. No ack_a is issued, state returns to IDLE, and a read of addr 1 returns 0x00.
